// File: rtl/adc_pipe_encoder_param.sv
`default_nettype none
// ============================================================================
// Module   : adc_pipe_encoder_param
// Purpose  : Pipelined 1.5-bit/stage ADC back-end with stage alignment,
//            overlap-add correction, invalid-code and clip flags.
// Revision : 1.0 - initial release
// ============================================================================
module adc_pipe_encoder_param #(
    parameter int NUM_STAGES = 2,
    parameter int LAST_BITS  = 1,
    parameter bit MSB_FIRST  = 1'b0,
    parameter int CNT_W      = 8
) (
    input  logic                            clock_i,
    input  logic                            reset_i,
    input  logic                            clear_i,
    input  logic                            valid_i,
    input  logic [3*NUM_STAGES-1:0]         d_stage_i,
    input  logic [LAST_BITS-1:0]            d_last_i,
    output logic [NUM_STAGES+LAST_BITS-1:0] d_o,
    output logic                            valid_o,
    output logic                            ovr_o,
    output logic                            err_o,
    output logic [CNT_W-1:0]                err_cnt_o
);
    localparam int               OUT_W     = NUM_STAGES + LAST_BITS;
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [2*NUM_STAGES-1:0] w_al_code;
    logic [NUM_STAGES-1:0]   w_al_err;

    // Each stage is decoded on arrival, then delayed so every stage of a sample
    // emerges in the same cycle as that sample's final flash code.
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam int c_depth = NUM_STAGES - k;

        logic [2:0] w_raw;
        logic [1:0] w_code;
        logic       w_inv;
        logic [2:0] r_sr [c_depth];

        assign w_raw = d_stage_i[3*k +: 3];

        always_comb begin
            w_code = 2'd1;
            w_inv  = 1'b0;
            case (w_raw)
                3'b001:  w_code = 2'd0;
                3'b010:  w_code = 2'd1;
                3'b100:  w_code = 2'd2;
                default: w_inv  = 1'b1;
            endcase
        end

        always_ff @(posedge clock_i or posedge reset_i) begin
            if (reset_i) begin
                for (int i = 0; i < c_depth; i++) r_sr[i] <= '0;
            end else begin
                r_sr[0] <= {w_inv, w_code};
                for (int i = 1; i < c_depth; i++) r_sr[i] <= r_sr[i-1];
            end
        end

        assign w_al_code[2*k +: 2] = r_sr[c_depth-1][1:0];
        assign w_al_err[k]         = r_sr[c_depth-1][2];
    end

    // Overlap-add: the full-scale sum is exactly 2^OUT_W-1, so OUT_W bits never overflow.
    logic [OUT_W-1:0] w_sum;
    always_comb begin
        w_sum = OUT_W'(d_last_i);
        for (int j = 0; j < NUM_STAGES; j++) begin
            w_sum = w_sum + (OUT_W'(w_al_code[2*j +: 2]) << (NUM_STAGES - 1 - j + LAST_BITS - 1));
        end
    end

    logic [OUT_W-1:0] w_word;
    if (MSB_FIRST) begin : g_msb_first
        assign w_word = w_sum;
    end else begin : g_msb_last
        for (genvar i = 0; i < OUT_W; i++) begin : g_rev
            assign w_word[i] = w_sum[OUT_W-1-i];
        end
    end

    logic w_ovr;
    logic w_err;
    assign w_ovr = (w_sum == '0) || (w_sum == '1);
    assign w_err = |w_al_err;

    logic [OUT_W-1:0]    r_d;
    logic                r_ovr;
    logic                r_err;
    logic [NUM_STAGES:0] r_vpipe;
    logic [CNT_W-1:0]    r_cnt;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_d     <= '0;
            r_ovr   <= 1'b0;
            r_err   <= 1'b0;
            r_vpipe <= '0;
            r_cnt   <= '0;
        end else begin
            r_d   <= w_word;
            r_ovr <= w_ovr;
            r_err <= w_err;
            if (clear_i) begin
                r_vpipe <= '0;
                r_cnt   <= '0;
            end else begin
                r_vpipe <= {r_vpipe[NUM_STAGES-1:0], valid_i};
                if (r_vpipe[NUM_STAGES] && r_err && (r_cnt != c_cnt_max)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign d_o       = r_d;
    assign ovr_o     = r_ovr;
    assign err_o     = r_err;
    assign valid_o   = r_vpipe[NUM_STAGES];
    assign err_cnt_o = r_cnt;

endmodule
`default_nettype wire
